dot_product_mac: RTL and testbench



---
 rtl/dot_product_mac.sv | 127 ++++++++++++
 tb/tb_dot_product_mac.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_mac.sv
// rtl/dot_product_mac.sv - sequential signed dot-product multiply-accumulate engine
//
// Accepts one signed a/b element pair per in_valid/in_ready handshake,
// accumulates VEC_LEN products into an ACC_WIDTH accumulator (wrapping or
// saturating on overflow) and holds the result until out_ready.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid, in_ready  element-pair handshake
//   a, b                signed BIT_WIDTH operands
//   out_valid, out_ready result handshake
//   result              signed ACC_WIDTH dot product (0 when not valid)
//   overflow            sticky step-overflow flag for the vector
//   negative            result sign bit
module dot_product_mac #(
  parameter int BIT_WIDTH = 8,
  parameter int VEC_LEN   = 4,
  parameter int ACC_WIDTH = 16,
  parameter int SATURATE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 overflow,
  output logic                 negative
);

  localparam int PW = 2 * BIT_WIDTH;
  localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [1:0]           state;
  logic [CW-1:0]        count;
  logic [ACC_WIDTH-1:0] acc;
  logic                 ovf;
  // Cleared by reset, set on the first edge after release, so in_ready
  // only rises one clock after rst deasserts.
  logic                 run;

  logic signed [PW-1:0]        a_ext;
  logic signed [PW-1:0]        b_ext;
  logic signed [PW-1:0]        product;
  logic signed [ACC_WIDTH-1:0] product_ext;
  logic [ACC_WIDTH:0]          sum_wide;
  logic                        step_ovf;
  logic [ACC_WIDTH-1:0]        next_acc;
  logic                        accept;

  assign a_ext       = PW'($signed(a));
  assign b_ext       = PW'($signed(b));
  assign product     = a_ext * b_ext;
  assign product_ext = ACC_WIDTH'(product);

  // One extra sign bit: the top two bits disagree exactly when the
  // ACC_WIDTH sum left the representable range; bit ACC_WIDTH is the true sign.
  assign sum_wide = {acc[ACC_WIDTH-1], acc} + {product_ext[ACC_WIDTH-1], product_ext};
  assign step_ovf = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];

  always_comb begin
    next_acc = sum_wide[ACC_WIDTH-1:0];
    if (SATURATE != 0 && step_ovf) begin
      next_acc = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
  end

  assign in_ready  = run && (state != S_DONE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_DONE);
  assign result    = out_valid ? acc : '0;
  assign overflow  = out_valid && ovf;
  assign negative  = result[ACC_WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      count <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
      run   <= 1'b0;
    end else begin
      run <= 1'b1;
      case (state)
        S_IDLE, S_ACCUM: begin
          if (accept) begin
            acc <= next_acc;
            ovf <= ovf | step_ovf;
            if (count == LAST) begin
              state <= S_DONE;
              count <= '0;
            end else begin
              state <= S_ACCUM;
              count <= count + CW'(1);
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
            count <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          count <= '0;
          acc   <= '0;
          ovf   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_mac.sv
// tb/tb_dot_product_mac.sv - self-checking bench for dot_product_mac (wrap and saturate instances)
module tb_dot_product_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;

  logic        in_ready0, out_valid0, overflow0, negative0;
  logic [15:0] result0;
  logic        in_ready1, out_valid1, overflow1, negative1;
  logic [15:0] result1;

  int checks = 0;
  int failures = 0;
  int accepts = 0;

  always #5 clk = ~clk;

  dot_product_mac #(.BIT_WIDTH(8), .VEC_LEN(4), .ACC_WIDTH(16), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .a(a), .b(b),
    .out_valid(out_valid0), .out_ready(out_ready), .result(result0),
    .overflow(overflow0), .negative(negative0)
  );

  dot_product_mac #(.BIT_WIDTH(8), .VEC_LEN(4), .ACC_WIDTH(16), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .a(a), .b(b),
    .out_valid(out_valid1), .out_ready(out_ready), .result(result1),
    .overflow(overflow1), .negative(negative1)
  );

  always @(posedge clk) if (in_valid && in_ready0) accepts++;

  typedef struct {
    byte va[4];
    byte vb[4];
    int  gap;
    int  exp_wrap;
    int  ovf_wrap;
    int  exp_sat;
    int  ovf_sat;
  } vec_t;

  vec_t tbl[5];
  byte  cur_a[4];
  byte  cur_b[4];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Reference: plain integer accumulation with explicit range handling.
  task automatic model(output int rw, output int ow, output int rs, output int os);
    int t;
    rw = 0; ow = 0; rs = 0; os = 0;
    for (int i = 0; i < 4; i++) begin
      t = rw + int'(cur_a[i]) * int'(cur_b[i]);
      if (t > 32767)       begin ow = 1; t -= 65536; end
      else if (t < -32768) begin ow = 1; t += 65536; end
      rw = t;
      t = rs + int'(cur_a[i]) * int'(cur_b[i]);
      if (t > 32767)       begin os = 1; t = 32767; end
      else if (t < -32768) begin os = 1; t = -32768; end
      rs = t;
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input int gap);
    int n;
    for (int i = 0; i < 4; i++) begin
      a = cur_a[i];
      b = cur_b[i];
      in_valid = 1'b1;
      n = 0;
      while (!in_ready0 && n < 20) begin step(); n++; end
      if (n == 20) chk("in_ready_timeout", 0, 1);
      step();
      in_valid = 1'b0;
      if (i < 3) repeat (gap) step();
    end
  endtask

  task automatic check_done(input string name, input int ew, input int ow, input int es, input int os);
    chk({name, "_out_valid"}, int'(out_valid0 & out_valid1), 1);
    chk({name, "_in_ready"}, int'(in_ready0 | in_ready1), 0);
    chk({name, "_result_wrap"}, int'($signed(result0)), ew);
    chk({name, "_ovf_wrap"}, int'(overflow0), ow);
    chk({name, "_neg_wrap"}, int'(negative0), int'(ew < 0));
    chk({name, "_result_sat"}, int'($signed(result1)), es);
    chk({name, "_ovf_sat"}, int'(overflow1), os);
    chk({name, "_neg_sat"}, int'(negative1), int'(es < 0));
  endtask

  task automatic release_result(input string name);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({name, "_idle_valid"}, int'(out_valid0 | out_valid1), 0);
    chk({name, "_idle_result"}, int'(result0 | result1), 0);
    chk({name, "_idle_flags"}, int'(overflow0 | overflow1 | negative0 | negative1), 0);
    chk({name, "_idle_ready"}, int'(in_ready0 & in_ready1), 1);
  endtask

  initial begin
    int base, rw, ow, rs, os, hold;

    tbl[0] = '{'{1, 2, 3, 4}, '{5, 6, 7, 8}, 0, 70, 0, 70, 0};
    tbl[1] = '{'{-20, 0, 3, 0}, '{10, 9, -5, -128}, 2, -215, 0, -215, 0};
    tbl[2] = '{'{127, 127, 127, 127}, '{127, 127, 127, 127}, 0, -1020, 1, 32767, 1};
    tbl[3] = '{'{-128, -128, -128, -128}, '{127, 127, 127, 127}, 1, 512, 1, -32768, 1};
    tbl[4] = '{'{1, 1, 1, 1}, '{1, 1, 1, 1}, 0, 4, 0, 4, 0};

    // Reset state and synchronous release of in_ready
    #2;
    chk("rst_in_ready", int'(in_ready0 | in_ready1), 0);
    chk("rst_out_valid", int'(out_valid0 | out_valid1), 0);
    chk("rst_result", int'(result0 | result1), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_in_ready_before_edge", int'(in_ready0 | in_ready1), 0);
    step();
    chk("rel_in_ready_after_edge", int'(in_ready0 & in_ready1), 1);

    // Table-driven vectors
    for (int k = 0; k < 5; k++) begin
      cur_a = tbl[k].va;
      cur_b = tbl[k].vb;
      base = accepts;
      send_vec(tbl[k].gap);
      chk($sformatf("tbl%0d_accepts", k), accepts - base, 4);
      check_done($sformatf("tbl%0d", k), tbl[k].exp_wrap, tbl[k].ovf_wrap,
                 tbl[k].exp_sat, tbl[k].ovf_sat);
      release_result($sformatf("tbl%0d", k));
    end

    // Backpressure: in_valid pulsed while DONE is held
    cur_a = '{1, 2, 3, 4};
    cur_b = '{5, 6, 7, 8};
    send_vec(0);
    base = accepts;
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0];
      a = 8'($urandom);
      b = 8'($urandom);
      step();
      check_done($sformatf("bp%0d", c), 70, 0, 70, 0);
    end
    in_valid = 1'b1;
    release_result("bp");
    in_valid = 1'b0;
    chk("bp_no_accepts", accepts - base, 0);
    cur_a = '{1, 1, 1, 1};
    cur_b = '{1, 1, 1, 1};
    send_vec(0);
    check_done("bp_next", 4, 0, 4, 0);
    release_result("bp_next");

    // Reset between edges after two accepts
    a = 8'd100; b = 8'd100; in_valid = 1'b1;
    step(); step();
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("abort_in_ready", int'(in_ready0 | in_ready1), 0);
    chk("abort_out", int'(out_valid0 | out_valid1 | overflow0 | negative0), 0);
    chk("abort_result", int'(result0 | result1), 0);
    #10;
    rst = 1'b0;
    #1;
    chk("abort_rel_ready_low", int'(in_ready0 | in_ready1), 0);
    step();
    cur_a = '{2, 2, 2, 2};
    cur_b = '{3, 3, 3, 3};
    send_vec(0);
    check_done("abort_next", 24, 0, 24, 0);
    release_result("abort_next");

    // Randomised vectors against the reference model
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 4; i++) begin
        cur_a[i] = byte'($urandom);
        cur_b[i] = byte'($urandom);
      end
      model(rw, ow, rs, os);
      base = accepts;
      send_vec(int'($urandom_range(0, 2)));
      hold = int'($urandom_range(0, 2));
      repeat (hold) step();
      chk($sformatf("rnd%0d_accepts", r), accepts - base, 4);
      check_done($sformatf("rnd%0d", r), rw, ow, rs, os);
      release_result($sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
